// File: rtl/alu_pipe_if.sv
// Request/response bundle for alu_pipe: operand/control request channel and
// result/flag response channel, each with its own valid/ready handshake.
interface alu_pipe_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [3:0]       ALU_control;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             cout;
  logic             overflow;
  logic             illegal;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output src1, src2, ALU_control, in_valid, out_ready,
    input  in_ready, result, zero, cout, overflow, illegal, out_valid
  );

  modport slave (
    input  src1, src2, ALU_control, in_valid, out_ready,
    output in_ready, result, zero, cout, overflow, illegal, out_valid
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: stage 1 registers operands plus per-byte P/G,
// stage 2 resolves byte carries, selects the result and registers flags.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  alu_pipe_if.slave bus
);
  localparam int NG = WIDTH / 8;

  if (WIDTH < 8 || (WIDTH % 8) != 0) begin : g_width_check
    $error("alu_pipe: WIDTH must be a multiple of 8 and at least 8");
  end

  logic [WIDTH-1:0] a_in, b_in, p_in, g_in;
  logic [NG-1:0]    gp_in, gg_in;

  assign a_in = bus.src1 ^ {WIDTH{bus.ALU_control[3]}};
  assign b_in = bus.src2 ^ {WIDTH{bus.ALU_control[2]}};
  assign p_in = a_in ^ b_in;
  assign g_in = a_in & b_in;

  always_comb begin
    gp_in = '0;
    gg_in = '0;
    for (int k = 0; k < NG; k++) begin
      gp_in[k] = &p_in[k*8 +: 8];
      for (int j = 0; j < 8; j++)
        gg_in[k] = g_in[k*8+j] | (p_in[k*8+j] & gg_in[k]);
    end
  end

  logic             s1_valid, s2_valid, s1_load, s2_load;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic             s1_cin;
  logic [3:0]       s1_ctl;
  logic [NG-1:0]    s1_gp, s1_gg;

  // in_ready depends only on state and out_ready, never on in_valid
  assign s2_load      = !s2_valid || bus.out_ready;
  assign s1_load      = !s1_valid || s2_load;
  assign bus.in_ready = s1_load;

  logic [WIDTH-1:0] p2, g2, sum, res_nx;
  logic [NG:0]      gcarry;
  logic [WIDTH:0]   carry;
  logic             ovf_add, cout_nx, ovf_nx, ill_nx;

  assign p2 = s1_a ^ s1_b;
  assign g2 = s1_a & s1_b;

  always_comb begin
    gcarry    = '0;
    carry     = '0;
    gcarry[0] = s1_cin;
    for (int k = 0; k < NG; k++)
      gcarry[k+1] = s1_gg[k] | (s1_gp[k] & gcarry[k]);
    for (int k = 0; k < NG; k++) begin
      carry[k*8] = gcarry[k];
      for (int j = 0; j < 7; j++)
        carry[k*8+j+1] = g2[k*8+j] | (p2[k*8+j] & carry[k*8+j]);
    end
    carry[WIDTH] = gcarry[NG];
  end

  assign sum     = p2 ^ carry[WIDTH-1:0];
  assign ovf_add = carry[WIDTH] ^ carry[WIDTH-1];

  always_comb begin
    res_nx  = '0;
    cout_nx = 1'b0;
    ovf_nx  = 1'b0;
    ill_nx  = 1'b0;
    case (s1_ctl)
      4'b0000, 4'b1100: res_nx = s1_a & s1_b;
      4'b0001, 4'b1101: res_nx = s1_a | s1_b;
      4'b0010, 4'b0110: begin
        res_nx  = sum;
        cout_nx = carry[WIDTH];
        ovf_nx  = ovf_add;
      end
      4'b0111: begin
        res_nx  = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_add};
        cout_nx = carry[WIDTH];
        ovf_nx  = ovf_add;
      end
      default: ill_nx = 1'b1;
    endcase
  end

  logic [WIDTH-1:0] res_q;
  logic             zero_q, cout_q, ovf_q, ill_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      if (s1_load) s1_valid <= bus.in_valid;
      if (s2_load) begin
        s2_valid <= s1_valid;
        // flags only move when a real op lands, so an empty slot holds the last result
        if (s1_valid) begin
          res_q  <= res_nx;
          zero_q <= (res_nx == '0);
          cout_q <= cout_nx;
          ovf_q  <= ovf_nx;
          ill_q  <= ill_nx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load && bus.in_valid) begin
      s1_a   <= a_in;
      s1_b   <= b_in;
      s1_cin <= bus.ALU_control[2];
      s1_ctl <= bus.ALU_control;
      s1_gp  <= gp_in;
      s1_gg  <= gg_in;
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: WIDTH=32 instance driven through a scoreboard,
// plus a WIDTH=8 instance for the narrow overflow case.
module tb_alu_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(32)) bus ();
  alu_pipe_if #(.WIDTH(8))  bus8 ();

  alu_pipe #(.WIDTH(32)) dut  (.clk(clk), .rst(rst), .bus(bus));
  alu_pipe #(.WIDTH(8))  dut8 (.clk(clk), .rst(rst), .bus(bus8));

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        c;
    logic        v;
    logic        il;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          checks = 0;
  int          failures = 0;
  int          run = 0;
  int          max_run = 0;
  logic [3:0]  codes [7];
  logic [31:0] snap_r;
  logic [3:0]  snap_f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [3:0] ctl, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [31:0] bi;
    logic [32:0] s;
    logic        v;
    e  = '0;
    bi = ctl[2] ? ~y : y;
    s  = {1'b0, x} + {1'b0, bi} + {32'd0, ctl[2]};
    v  = (x[31] == bi[31]) && (s[31] != x[31]);
    case (ctl)
      4'b0000: e.r = x & y;
      4'b0001: e.r = x | y;
      4'b1100: e.r = ~(x | y);
      4'b1101: e.r = ~(x & y);
      4'b0010, 4'b0110: begin e.r = s[31:0]; e.c = s[32]; e.v = v; end
      4'b0111: begin
        e.r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        e.c = s[32];
        e.v = v;
      end
      default: e.il = 1'b1;
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  // Called at posedge+1 with inputs set; observes the cycle, then advances one edge.
  task automatic tick();
    exp_t e;
    #1;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      chk("out_expected", {31'd0, q.size() > 0}, 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("result",   bus.result,            e.r);
        chk("zero",     {31'd0, bus.zero},     {31'd0, e.z});
        chk("cout",     {31'd0, bus.cout},     {31'd0, e.c});
        chk("overflow", {31'd0, bus.overflow}, {31'd0, e.v});
        chk("illegal",  {31'd0, bus.illegal},  {31'd0, e.il});
      end
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1 && !rst) q.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_empty", q.size(), 32'd0);
  endtask

  task automatic issue(input logic [3:0] ctl, input logic [31:0] x, input logic [31:0] y, input exp_t e);
    bus.ALU_control = ctl;
    bus.src1        = x;
    bus.src2        = y;
    bus.in_valid    = 1'b1;
    cur             = e;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101};
    rst = 1'b1;
    bus.src1 = '0; bus.src2 = '0; bus.ALU_control = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus8.src1 = '0; bus8.src2 = '0; bus8.ALU_control = '0; bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
    cur = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_result",    bus.result,             32'd0);
    chk("rst_zero",      {31'd0, bus.zero},      32'd0);
    chk("rst_cout",      {31'd0, bus.cout},      32'd0);
    chk("rst_overflow",  {31'd0, bus.overflow},  32'd0);
    chk("rst_illegal",   {31'd0, bus.illegal},   32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    @(posedge clk);
    #1;

    // ADD overflow with latency check
    issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, '{32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0});
    bus.in_valid = 1'b0;
    chk("lat_cycle1", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk("lat_cycle2", {31'd0, bus.out_valid}, 32'd1);
    drain(4);

    // SUB to zero, SLT negative vs positive, illegal code, NOR/NAND to zero
    issue(4'b0110, 32'h0000_0005, 32'h0000_0005, '{32'h0, 1'b1, 1'b1, 1'b0, 1'b0});
    issue(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, '{32'h1, 1'b0, 1'b1, 1'b0, 1'b0});
    issue(4'b0101, 32'hFFFF_FFFF, 32'h1234_5678, '{32'h0, 1'b1, 1'b0, 1'b0, 1'b1});
    issue(4'b1100, 32'h0F0F_0F0F, 32'hF0F0_F0F0, '{32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
    issue(4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
    issue(4'b0000, 32'hF0F0_FF00, 32'h3C3C_0FF0, '{32'h3030_0F00, 1'b0, 1'b0, 1'b0, 1'b0});
    issue(4'b0001, 32'h8000_0000, 32'h0000_0001, '{32'h8000_0001, 1'b0, 1'b0, 1'b0, 1'b0});
    issue(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, '{32'h0, 1'b1, 1'b1, 1'b0, 1'b0});
    issue(4'b0110, 32'h8000_0000, 32'h0000_0001, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0});
    issue(4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, '{32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
    bus.in_valid = 1'b0;
    drain(8);

    // back-to-back random ops at full throughput
    max_run = 0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0]  c;
      logic [31:0] x, y;
      c = codes[$urandom_range(0, 6)];
      x = $urandom();
      y = $urandom();
      issue(c, x, y, model(c, x, y));
    end
    bus.in_valid = 1'b0;
    drain(8);
    chk("b2b_run", max_run, 32'd16);

    // consumer stall with a continuously offered request
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] x;
      x = 32'(i + 1) * 32'h0101_0101;
      issue(4'b0010, x, 32'd10, model(4'b0010, x, 32'd10));
    end
    chk("stall_accepted", q.size(), 32'd2);
    chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
    snap_r = bus.result;
    snap_f = {bus.zero, bus.cout, bus.overflow, bus.illegal};
    tick();
    tick();
    chk("stall_hold_result", bus.result, snap_r);
    chk("stall_hold_flags", {28'd0, bus.zero, bus.cout, bus.overflow, bus.illegal}, {28'd0, snap_f});
    chk("stall_still_two", q.size(), 32'd2);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    max_run = 0;
    drain(6);
    chk("release_run", max_run, 32'd2);

    // reset with both stages full; a request offered during reset must vanish
    bus.out_ready = 1'b0;
    issue(4'b0010, 32'd1, 32'd2, model(4'b0010, 32'd1, 32'd2));
    issue(4'b0010, 32'd3, 32'd4, model(4'b0010, 32'd3, 32'd4));
    tick();
    chk("pre_rst_full", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    issue(4'b0010, 32'd5, 32'd6, model(4'b0010, 32'd5, 32'd6));
    rst = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    chk("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("post_rst_result",    bus.result,             32'd0);
    chk("post_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_stale_output", {31'd0, bus.out_valid}, 32'd0);
    end

    // narrow instance: 0x7F + 0x01 overflows into 0x80
    bus8.src1 = 8'h7F;
    bus8.src2 = 8'h01;
    bus8.ALU_control = 4'b0010;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    chk("w8_lat1", {31'd0, bus8.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("w8_out_valid", {31'd0, bus8.out_valid}, 32'd1);
    chk("w8_result",    {24'd0, bus8.result},    32'h80);
    chk("w8_overflow",  {31'd0, bus8.overflow},  32'd1);
    chk("w8_cout",      {31'd0, bus8.cout},      32'd0);
    chk("w8_zero",      {31'd0, bus8.zero},      32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
